// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter over 8 level requests with a valid/ready grant output.
// A grant, once presented, is held until accepted; the pointer then advances past the winner.
module rr_grant_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_idx,
  output logic [2:0] ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ptr_q, ptr_d;

  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  win_off;
  logic [2:0]  winner;

  // Rotate so that bit 0 is the channel at ptr; the lowest set bit is then the winner's offset.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[7:0];
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) win_off = 3'(i);
    end
    winner = ptr_q + win_off;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = winner;
        end
      end
      GRANT: begin
        if (out_ready) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == GRANT);
  assign out_idx   = idx_q;
  assign ptr       = ptr_q;

endmodule

// File: doc/rr_grant_encoder.md
RR_GRANT_ENCODER -- requirements
Module: rr_grant_encoder

Interface
REQ-001 Parameters SHALL be none; channel count is fixed at 8 and the index width at 3.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  level request per channel; bit i requests channel i.
REQ-005 out_ready  input  1  consumer accepts the current grant.
REQ-006 out_valid  output  1  a grant is presented on out_idx.
REQ-007 out_idx  output  3  binary index of the granted channel; drives the 3-to-8 one-hot decoder stage directly.
REQ-008 ptr  output  3  current round-robin priority pointer, for observation.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-010 In IDLE with req == 0, the FSM SHALL remain in IDLE, out_valid stays 0, and out_idx and ptr hold their values.
REQ-011 In IDLE with req != 0 at a rising edge, the block SHALL select the winner and enter GRANT on that same edge.
- The winner is the first set bit found scanning ptr, ptr+1, ... ptr+7, modulo 8.
- On that edge, out_idx is loaded with the winner and out_valid is set to 1.
- Latency from req sampled to out_valid high is 1 clock.
REQ-012 In GRANT with out_ready == 0, out_idx and out_valid SHALL hold stable every cycle, regardless of any change on req.
REQ-013 A grant SHALL NOT be retracted: if req[out_idx] drops while in GRANT, out_valid stays 1 until accepted.
REQ-014 Handshake SHALL complete on a rising edge with out_valid == 1 and out_ready == 1. On that edge:
- ptr is loaded with (out_idx + 1) mod 8; 7 wraps to 0.
- out_valid is cleared.
- the FSM returns to IDLE.
REQ-015 After each accepted grant, out_valid SHALL be low for at least one cycle; peak throughput is one grant per 2 clocks.
REQ-016 out_ready asserted while out_valid == 0 SHALL be ignored.
REQ-017 out_idx SHALL retain the last granted index while out_valid == 0.
REQ-018 Requests arriving on the same edge as an accept SHALL be arbitrated in the following IDLE cycle against the updated ptr.
REQ-019 With all req bits set continuously and out_ready == 1, successive grants SHALL cycle 0,1,2,...,7,0.
REQ-020 No channel SHALL wait more than 7 other grants while its req bit is held high.

Reset
REQ-021 While rst_n == 0, the block SHALL force the following immediately, independent of clk:
- state = IDLE
- out_valid = 0
- out_idx = 3'd0
- ptr = 3'd0
REQ-022 Reset asserted mid-grant SHALL drop out_valid immediately; the pending grant is discarded and not replayed.
REQ-023 After rst_n rises, the first arbitration SHALL occur on the first rising edge that samples req != 0.

Verification
REQ-024 The bench SHALL cover the following directed scenarios, plus a check that out_idx is stable whenever out_valid == 1 and out_ready == 0.
- Reset: rst_n = 0 mid-cycle with out_valid = 1 -> out_valid = 0, out_idx = 0, ptr = 0 before the next clk edge.
- Single request: req = 8'h01, out_ready = 1 -> out_valid = 1 one edge after sampling, out_idx = 0; after accept, ptr = 1 and out_valid = 0 for one cycle.
- Full load: req = 8'hFF held, out_ready = 1 -> out_idx sequence 0,1,2,3,4,5,6,7,0; out_valid pattern 1,0,1,0,...
- Backpressure: ptr = 0, req = 8'h24, out_ready = 0 for 5 cycles -> out_idx = 2 stable for 5 cycles.
  - Then req changes to 8'h80 while still stalled -> out_idx remains 2.
  - Then out_ready = 1 -> ptr = 3, and the next grant is out_idx = 7.
- Wrap: ptr = 6, req = 8'h41 -> grant 6, after which ptr = 7; with req = 8'h41 again -> grant 0, after which ptr = 1.
- Idle: req = 8'h00 for 10 cycles with out_ready toggling -> out_valid stays 0 and ptr is unchanged.
